// File: rtl/gamepad_pkg.sv
// Shared constants and types for the gamepad Pmod receive path.
// Frame layout: FRAME_BITS bits, NUM_PADS words of PAD_BITS each, first pad
// shifted in lands in the upper word. An all-ones pad word means "no
// controller present".
package gamepad_pkg;

    localparam int FRAME_BITS = 24;
    localparam int PAD_BITS   = 12;
    localparam int NUM_PADS   = 2;

    typedef logic [PAD_BITS-1:0] pad_word_t;

    localparam pad_word_t PAD_EMPTY = 12'hFFF;

    // Register value reported when no frame (or no recent frame) is available.
    localparam logic [FRAME_BITS-1:0] FRAME_EMPTY = {NUM_PADS{PAD_EMPTY}};

endpackage

// File: rtl/pmod_sync_edge.sv
// Brings one asynchronous Pmod pin into the clk domain.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   pin   - raw asynchronous pin
//   level - synchronized pin level
//   rise  - one-cycle registered pulse after a rising edge of the pin
module pmod_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic hist;

    // rise is registered so downstream logic sees a clean flop output; this
    // is the extra stage that places a latch update three edges after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
            rise <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            hist <= sync;
            rise <= sync & ~hist;
        end
    end

    assign level = sync;

endmodule

// File: rtl/gamepad_pmod_driver.sv
// Receives the gamepad Pmod serial stream and publishes the last good frame.
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   pmod_data           - serial data pin (level used, MSB first)
//   pmod_clk            - bit clock pin, data taken on its rising edge
//   pmod_latch          - frame-end strobe pin (rising edge ends a frame)
//   data_reg[23:0]      - last valid frame, [23:12] pad 1, [11:0] pad 0
//   data_valid          - one-cycle pulse when data_reg loads a good frame
//   frame_error         - one-cycle pulse when a frame had != 24 bits
// Configuration macro: GAMEPAD_TIMEOUT_EN enables a watchdog that forces
// data_reg to all-ones after TIMEOUT_CYCLES clocks without a valid frame.
module gamepad_pmod_driver
    import gamepad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_048_576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pmod_data,
    input  logic                  pmod_clk,
    input  logic                  pmod_latch,
    output logic [FRAME_BITS-1:0] data_reg,
    output logic                  data_valid,
    output logic                  frame_error
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_MAX  = 5'd31;

    logic data_lvl;
    logic data_rise_unused;
    logic clk_lvl_unused;
    logic clk_rise;
    logic latch_lvl_unused;
    logic latch_rise;

    logic [FRAME_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt;
    logic                  good_latch;

    pmod_sync_edge u_sync_data (
        .clk   (clk),
        .rst   (rst),
        .pin   (pmod_data),
        .level (data_lvl),
        .rise  (data_rise_unused)
    );

    pmod_sync_edge u_sync_clk (
        .clk   (clk),
        .rst   (rst),
        .pin   (pmod_clk),
        .level (clk_lvl_unused),
        .rise  (clk_rise)
    );

    pmod_sync_edge u_sync_latch (
        .clk   (clk),
        .rst   (rst),
        .pin   (pmod_latch),
        .level (latch_lvl_unused),
        .rise  (latch_rise)
    );

    assign good_latch = latch_rise && (bit_cnt == CNT_FULL);

    // A latch and a bit clock in the same cycle: the latch judges the old
    // frame, and the bit becomes the first bit of the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            data_valid  <= good_latch;
            frame_error <= latch_rise && !good_latch;
            if (clk_rise) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], data_lvl};
                if (latch_rise)
                    bit_cnt <= 5'd1;
                else if (bit_cnt != CNT_MAX)
                    bit_cnt <= bit_cnt + 5'd1;
            end else if (latch_rise) begin
                bit_cnt <= '0;
            end
        end
    end

`ifdef GAMEPAD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_TC = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;

    assign wd_hit = (wd_cnt == WD_TC);

    // Sticks at terminal count until the next good frame restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if (data_valid)
            wd_cnt <= '0;
        else if (!wd_hit)
            wd_cnt <= wd_cnt + WD_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_reg <= FRAME_EMPTY;
        else if (good_latch)
            data_reg <= shift_reg;
        else if (wd_hit)
            data_reg <= FRAME_EMPTY;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_reg <= FRAME_EMPTY;
        else if (good_latch)
            data_reg <= shift_reg;
    end
`endif

endmodule

// File: tb/tb_gamepad_pmod_driver.sv
// Self-checking bench for gamepad_pmod_driver. The reference model keeps the
// bits seen since the last latch in a queue and judges each latch by the
// queue length; the expected register is the queue packed MSB first.
// With GAMEPAD_TIMEOUT_EN defined the watchdog scenario is also exercised.
module tb_gamepad_pmod_driver;

    logic        clk;
    logic        rst;
    logic        pmod_data;
    logic        pmod_clk;
    logic        pmod_latch;
    logic [23:0] data_reg;
    logic        data_valid;
    logic        frame_error;

    int total = 0;
    int bad   = 0;

    bit          model_bits[$];
    logic [23:0] model_reg;

    gamepad_pmod_driver #(.TIMEOUT_CYCLES(1000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pmod_data   (pmod_data),
        .pmod_clk    (pmod_clk),
        .pmod_latch  (pmod_latch),
        .data_reg    (data_reg),
        .data_valid  (data_valid),
        .frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL sim_timeout: run exceeded time limit, bad=%0d", bad);
        $fatal(1, "time limit");
    end

    // Pins change on negedge; each bit is a 3-high / 3-low clock pulse with
    // data settled two cycles before the rising edge.
    task automatic send_bit(input bit b);
        pmod_data = b;
        repeat (2) @(negedge clk);
        pmod_clk = 1'b1;
        repeat (3) @(negedge clk);
        pmod_clk = 1'b0;
        repeat (3) @(negedge clk);
        model_bits.push_back(b);
    endtask

    task automatic send_word(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--)
            send_bit(val[i % 32]);
    endtask

    // Raises latch (optionally together with a new bit clock) and checks the
    // pulse kind, its timing (3 edges after capture) and the register.
    task automatic do_latch(input string name, input bit with_bit, input bit b);
        bit          exp_good;
        logic [23:0] packed_bits;
        int          nv;
        int          ne;
        int          first;
        if (with_bit) begin
            pmod_data = b;
            repeat (2) @(negedge clk);
            pmod_clk = 1'b1;
        end
        pmod_latch = 1'b1;
        exp_good = (model_bits.size() == 24);
        packed_bits = '0;
        foreach (model_bits[i])
            packed_bits = {packed_bits[22:0], model_bits[i]};
        if (exp_good)
            model_reg = packed_bits;
        model_bits.delete();
        if (with_bit)
            model_bits.push_back(b);
        nv = 0;
        ne = 0;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3)
                pmod_clk = 1'b0;
            if (data_valid || frame_error) begin
                if (first == 0)
                    first = k;
            end
            if (data_valid)
                nv++;
            if (frame_error)
                ne++;
        end
        pmod_latch = 1'b0;
        repeat (3) @(negedge clk);

        total++;
        if (nv !== (exp_good ? 1 : 0)) begin
            bad++;
            $display("FAIL %s valid_pulses: got %0d expected %0d", name, nv, exp_good ? 1 : 0);
        end
        total++;
        if (ne !== (exp_good ? 0 : 1)) begin
            bad++;
            $display("FAIL %s error_pulses: got %0d expected %0d", name, ne, exp_good ? 0 : 1);
        end
        total++;
        if (first !== 4) begin
            bad++;
            $display("FAIL %s pulse_latency: got k=%0d expected k=4", name, first);
        end
        total++;
        if (data_reg !== model_reg) begin
            bad++;
            $display("FAIL %s data_reg: got %h expected %h", name, data_reg, model_reg);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pmod_data = 1'b0;
        pmod_clk = 1'b0;
        pmod_latch = 1'b0;
        model_bits.delete();
        model_reg = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if (data_reg !== 24'hFFFFFF || data_valid !== 1'b0 || frame_error !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle: cycle %0d got reg=%h v=%b e=%b expected reg=ffffff v=0 e=0",
                         i, data_reg, data_valid, frame_error);
            end
        end
    endtask

    task automatic test_known_frame();
        send_word(32'h00A53C0F, 24);
        do_latch("known_frame", 1'b0, 1'b0);
        total++;
        if (data_reg[23:12] !== 12'hA53) begin
            bad++;
            $display("FAIL known_frame pad1: got %h expected a53", data_reg[23:12]);
        end
    endtask

    task automatic test_bad_lengths();
        send_word(32'h0012_3456, 23);
        do_latch("short_23", 1'b0, 1'b0);
        send_word(32'h0155_AAAA, 25);
        do_latch("long_25", 1'b0, 1'b0);
        send_word(32'h00FF_00FF, 24);
        do_latch("refill", 1'b0, 1'b0);
        send_word(32'hDEAD_BEEF, 24);
        send_word(32'h0000_01FF, 9);
        do_latch("saturate_33", 1'b0, 1'b0);
    endtask

    task automatic test_random_frames();
        int len;
        for (int it = 0; it < 8; it++) begin
            if (it % 2 == 0) begin
                len = 24;
            end else begin
                len = $urandom_range(0, 31);
                if (len == 24)
                    len = 26;
            end
            send_word($urandom, len);
            do_latch($sformatf("random_%0d_len%0d", it, len), 1'b0, 1'b0);
        end
        send_word(32'h00FF_FFFF, 24);
        do_latch("all_ones", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_word(32'h0081_7E42, 24);
        do_latch("b2b_prev", 1'b1, 1'b1);
        send_word(32'h0000_2C3D, 23);
        do_latch("b2b_next", 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        send_word(32'h0000_0ABC, 24);
        do_latch("pre_reset", 1'b0, 1'b0);
        send_word(32'h0000_0F0F, 12);
        rst = 1'b1;
        #1;
        total++;
        if (data_reg !== 24'hFFFFFF || data_valid !== 1'b0 || frame_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_frame: got reg=%h v=%b e=%b expected reg=ffffff v=0 e=0",
                     data_reg, data_valid, frame_error);
        end
        model_bits.delete();
        model_reg = 24'hFFFFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(32'h0000_0333, 12);
        do_latch("after_reset", 1'b0, 1'b0);
    endtask

`ifdef GAMEPAD_TIMEOUT_EN
    task automatic test_timeout();
        send_word(32'h0000_0123, 24);
        do_latch("timeout_frame", 1'b0, 1'b0);
        repeat (880) @(negedge clk);
        total++;
        if (data_reg !== 24'h000123) begin
            bad++;
            $display("FAIL timeout_early: got %h expected 000123", data_reg);
        end
        repeat (200) @(negedge clk);
        total++;
        if (data_reg !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL timeout_fired: got %h expected ffffff", data_reg);
        end
        model_reg = 24'hFFFFFF;
        send_word(32'h0045_6789, 24);
        do_latch("timeout_recover", 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_known_frame();
        test_bad_lengths();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef GAMEPAD_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gamepad_pmod_driver.md
# gamepad_pmod_driver

Receives the serial frame streamed by the gamepad Pmod and presents it as a parallel per-controller data register. Oversamples the asynchronous `pmod_latch`, `pmod_clk` and `pmod_data` pins in the system clock domain, shifts in bits, and validates frame length. Publishes a stable 24-bit register: two 12-bit words, one per controller. Sits directly upstream of `gamepad_pmod_decoder`; each 12-bit half feeds one decoder instance.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_048_576: clk cycles without a valid frame before the register is forced to "not present". Used only with the timeout feature.

Ports:
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  asynchronous, active-high reset.
- `pmod_data`  input  1  serial data pin; asynchronous.
- `pmod_clk`  input  1  serial bit clock pin; asynchronous. Data is valid at its rising edge.
- `pmod_latch`  input  1  frame-end strobe pin; asynchronous.
- `data_reg`  output  24  last valid frame. `[23:12]` holds pad 1 (first 12 bits shifted). `[11:0]` holds pad 0.
- `data_valid`  output  1  one-cycle pulse when `data_reg` is updated from a good frame.
- `frame_error`  output  1  one-cycle pulse when a latch ends a frame whose bit count is not 24.

## Operation
- Each pin passes through a 2-FF synchronizer followed by one history flop. A rising edge is `sync & ~hist`.
- On a `pmod_clk` rising edge:
  - `shift_reg <= {shift_reg[22:0], data_sync}`, MSB first.
  - `bit_cnt` (5 bits) increments and saturates at 31.
- On a `pmod_latch` rising edge:
  - If `bit_cnt == 24`: `data_reg <= shift_reg` and `data_valid` pulses.
  - Otherwise: `data_reg` is unchanged and `frame_error` pulses.
  - In both cases `bit_cnt <= 0`.
- Simultaneous latch edge and clk edge in the same cycle:
  - The latch evaluates the old `shift_reg` and old `bit_cnt`.
  - The clock bit then starts the new frame: shift applied, `bit_cnt <= 1`.
- Any bit count above 24 (including saturation at 31) is an error; the frame is never truncated.
- Falling edges of `pmod_latch` and `pmod_clk` are ignored.
- `pmod_data` is not edge-detected; only its synchronized level is used.
- All-ones `data_reg` means "no controller present" to the downstream decoder. A frame of 24 ones is therefore passed through unchanged.

## Timing
- Reset values:
  - `data_reg` = 24'hFFFFFF
  - `data_valid` = 0, `frame_error` = 0
  - `shift_reg` = 0, `bit_cnt` = 0
  - all synchronizer and history flops = 0
- Latency: a latch pin rising edge sampled at clk edge N updates `data_reg` and `data_valid` at edge N+3. Both outputs are registered.
- `data_valid` and `frame_error` are high for exactly one cycle and are mutually exclusive.
- Input requirement: `pmod_clk` high and low phases, and the `pmod_latch` high phase, are each at least 3 clk periods. `pmod_data` is stable for 3 clk periods around the `pmod_clk` rising edge.
- Reset asserted mid-frame: all state returns to reset values immediately. The first latch after release reports `frame_error` unless 24 fresh clocks are received.

## Configuration
- `GAMEPAD_TIMEOUT_EN` defined:
  - A watchdog counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on every `data_valid` and otherwise increments.
  - On reaching `TIMEOUT_CYCLES`, it loads `data_reg <= 24'hFFFFFF` and holds at terminal count until the next valid frame.
  - No pulse is emitted on timeout.
  - Counter reset value is 0.
- `GAMEPAD_TIMEOUT_EN` undefined: no watchdog logic; `data_reg` holds the last valid frame indefinitely. `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `gamepad_pkg` holds:
  - `FRAME_BITS` = 24
  - `PAD_BITS` = 12
  - `NUM_PADS` = 2
  - `PAD_EMPTY` = 12'hFFF
  - typedef `pad_word_t` (logic [PAD_BITS-1:0])
- One sub-module is natural: `pmod_sync_edge` (2-FF synchronizer, history flop, `level` and `rise` outputs). Instantiated three times; the `rise` output of the `pmod_data` instance is left unused.

## Test plan
- Reset only → `data_reg` = 24'hFFFFFF; no pulses for 100 cycles.
- Shift 24 bits 24'hA5_3C_0F, then latch → `data_reg` = 24'hA53C0F at latch edge +3; one `data_valid`; `[23:12]` = 12'hA53.
- 23 bits then latch, and separately 25 bits then latch → `frame_error` each time; `data_reg` keeps its previous value; no `data_valid`.
- Latch edge coincides with the first clk edge of the next frame (bit = 1) → previous frame accepted; the following 23 bits plus latch complete a valid frame.
- Assert `rst` after 12 bits → immediate 24'hFFFFFF. Next latch after 12 more bits → `frame_error`.
- With `GAMEPAD_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 1000: valid frame 24'h000123, then idle → `data_reg` = 24'hFFFFFF 1000 cycles after `data_valid`. The next valid frame restores normal output.
